// File: rtl/simon_pattern_player.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | simon_pattern_player: generates an LFSR colour pattern and replays it on   |
// | one-hot LEDs, paced by an external one-shot timer. Optional inter-step     |
// | dark gap enabled by macro PLAYER_GAP_EN.                                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module simon_pattern_player #(
  parameter int STEPS_MAX = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         new_game,
  input  logic [15:0]                  seed,
  input  logic                         play,
  input  logic [$clog2(STEPS_MAX)-1:0] level,
  input  logic                         timer_done,
  output logic                         start_timer,
  output logic [3:0]                   led,
  output logic                         busy,
  output logic                         play_done,
  input  logic [$clog2(STEPS_MAX)-1:0] rd_idx,
  output logic [1:0]                   rd_color
);

  localparam int          IDX_W      = $clog2(STEPS_MAX);
  localparam logic [15:0] LFSR_INIT  = 16'hACE1;
  localparam logic [1:0]  ARM_CYCLES = 2'd2;
`ifdef PLAYER_GAP_EN
  localparam bit          GAP_EN     = 1'b1;
`else
  localparam bit          GAP_EN     = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GEN  = 3'd1,
    S_SHOW = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state;
  logic [1:0]       mem [STEPS_MAX];
  logic [15:0]      lfsr;
  logic [IDX_W-1:0] gen_idx;
  logic [IDX_W-1:0] step;
  logic [IDX_W-1:0] last;
  logic [1:0]       arm;
  logic             lfsr_fb;
  logic             timed_exit;
  logic [IDX_W-1:0] step_next;

  function automatic logic [3:0] color_led(input logic [1:0] c);
    color_led = 4'b0001 << c;
  endfunction

  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  // arm counts down through the start_timer cycle and the one after it
  assign timed_exit = (arm == 2'd0) && timer_done;
  assign step_next  = step + 1'b1;
  assign busy       = (state == S_GEN) || (state == S_SHOW) || (state == S_GAP);
  assign rd_color   = mem[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      led         <= 4'b0000;
      start_timer <= 1'b0;
      play_done   <= 1'b0;
      step        <= '0;
      last        <= '0;
      gen_idx     <= '0;
      lfsr        <= LFSR_INIT;
      arm         <= 2'd0;
      for (int i = 0; i < STEPS_MAX; i++) mem[i] <= 2'd0;
    end else begin
      start_timer <= 1'b0;
      play_done   <= 1'b0;
      if (arm != 2'd0) arm <= arm - 2'd1;
      case (state)
        S_IDLE: begin
          if (new_game) begin
            lfsr    <= (seed == 16'd0) ? LFSR_INIT : seed;
            gen_idx <= '0;
            state   <= S_GEN;
          end else if (play) begin
            last        <= level;
            step        <= '0;
            led         <= color_led(mem[0]);
            start_timer <= 1'b1;
            arm         <= ARM_CYCLES;
            state       <= S_SHOW;
          end
        end
        S_GEN: begin
          mem[gen_idx] <= lfsr[1:0];
          lfsr         <= {lfsr[14:0], lfsr_fb};
          gen_idx      <= gen_idx + 1'b1;
          if (gen_idx == IDX_W'(STEPS_MAX - 1)) state <= S_IDLE;
        end
        S_SHOW, S_GAP: begin
          if (timed_exit) begin
            if (GAP_EN && (state == S_SHOW)) begin
              led         <= 4'b0000;
              start_timer <= 1'b1;
              arm         <= ARM_CYCLES;
              state       <= S_GAP;
            end else if (step == last) begin
              led       <= 4'b0000;
              play_done <= 1'b1;
              state     <= S_DONE;
            end else begin
              step        <= step_next;
              led         <= color_led(mem[step_next]);
              start_timer <= 1'b1;
              arm         <= ARM_CYCLES;
              state       <= S_SHOW;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_simon_pattern_player.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_simon_pattern_player: directed self-checking bench with timer stub.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_simon_pattern_player;

  localparam int STEPS = 16;
`ifdef PLAYER_GAP_EN
  localparam int GAP_EN = 1;
`else
  localparam int GAP_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_game = 1'b0;
  logic [15:0] seed = 16'd0;
  logic        play = 1'b0;
  logic [3:0]  level = 4'd0;
  logic        timer_done;
  logic        start_timer;
  logic [3:0]  led;
  logic        busy;
  logic        play_done;
  logic [3:0]  rd_idx = 4'd0;
  logic [1:0]  rd_color;
  logic [2:0]  tcnt;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [1:0] ref_mem [STEPS];

  simon_pattern_player #(.STEPS_MAX(STEPS)) dut (
    .clk(clk), .reset(reset), .new_game(new_game), .seed(seed), .play(play),
    .level(level), .timer_done(timer_done), .start_timer(start_timer), .led(led),
    .busy(busy), .play_done(play_done), .rd_idx(rd_idx), .rd_color(rd_color)
  );

  always #5 clk = ~clk;

  // timer stub: done drops the cycle after start_timer, returns 4 cycles later
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            tcnt <= 3'd0;
    else if (start_timer) tcnt <= 3'd4;
    else if (tcnt != 0)   tcnt <= tcnt - 3'd1;
  end
  assign timer_done = (tcnt == 3'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ref_gen(input logic [15:0] s);
    logic [15:0] l;
    l = (s == 16'd0) ? 16'hACE1 : s;
    for (int i = 0; i < STEPS; i++) begin
      ref_mem[i] = l[1:0];
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
  endtask

  task automatic verify_mem(input string tag);
    for (int i = 0; i < STEPS; i++) begin
      rd_idx = 4'(i);
      #1;
      check($sformatf("%s[%0d]", tag, i), 32'(rd_color), 32'(ref_mem[i]));
    end
  endtask

  task automatic do_gen(input logic [15:0] s, input bit with_play, input bit inject);
    int busy_cyc = 0, leds = 0, dones = 0;
    @(negedge clk);
    seed = s; new_game = 1'b1; play = with_play; level = 4'd3;
    @(negedge clk);
    new_game = 1'b0; play = 1'b0;
    ref_gen(s);
    for (int c = 0; c < 40; c++) begin
      if (busy) busy_cyc++;
      if (led != 4'd0) leds++;
      if (play_done) dones++;
      new_game = 1'b0; play = 1'b0;
      if (inject && c == 5) begin new_game = 1'b1; play = 1'b1; seed = 16'h1234; end
      @(negedge clk);
    end
    new_game = 1'b0; play = 1'b0;
    check("gen_busy_cycles", busy_cyc, 16);
    check("gen_no_led", leds, 0);
    check("gen_no_done", dones, 0);
    verify_mem("gen_mem");
  endtask

  task automatic do_play(input logic [3:0] lvl, input bit inject);
    int shows = 0, gaps = 0, dones = 0, cyc = 0, dbl = 0, stray = 0;
    bit fin = 1'b0;
    logic prev_st = 1'b0;
    @(negedge clk);
    level = lvl; play = 1'b1;
    @(negedge clk);
    play = 1'b0; level = 4'd0;
    while (!fin && cyc < 2000) begin
      if (start_timer && led != 4'd0) begin
        if (shows < STEPS)
          check($sformatf("show_led_step%0d", shows), 32'(led), 32'd1 << ref_mem[shows]);
        shows++;
      end
      if (start_timer && led == 4'd0) gaps++;
      if (start_timer && prev_st) dbl++;
      if (led != 4'd0 && !busy) stray++;
      if (play_done) begin
        dones++; fin = 1'b1;
        check("done_busy_low", 32'(busy), 0);
        check("done_led_dark", 32'(led), 0);
      end
      prev_st = start_timer;
      new_game = 1'b0; play = 1'b0;
      if (inject && cyc == 10) begin new_game = 1'b1; play = 1'b1; seed = 16'h5555; end
      @(negedge clk);
      cyc++;
    end
    new_game = 1'b0; play = 1'b0;
    check("play_finished", 32'(fin), 1);
    for (int c = 0; c < 10; c++) begin
      if (play_done) dones++;
      if (busy || led != 4'd0) stray++;
      @(negedge clk);
    end
    check("play_shows", shows, int'(lvl) + 1);
    check("play_gap_timers", gaps, GAP_EN * (int'(lvl) + 1));
    check("play_done_count", dones, 1);
    check("play_no_double_start", dbl, 0);
    check("play_no_stray_led", stray, 0);
    verify_mem("play_mem");
  endtask

  initial begin
    int shows, cyc;
    for (int i = 0; i < STEPS; i++) ref_mem[i] = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_led", 32'(led), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_start_timer", 32'(start_timer), 0);
    check("rst_play_done", 32'(play_done), 0);
    verify_mem("rst_mem");
    reset = 1'b0;
    @(negedge clk);

    do_gen(16'h0000, 1'b0, 1'b1);
    do_play(4'd2, 1'b1);
    do_play(4'd15, 1'b0);
    do_gen(16'hBEEF, 1'b1, 1'b0);
    do_play(4'd5, 1'b0);

    // abort playback during the second step's display
    @(negedge clk);
    level = 4'd3; play = 1'b1;
    @(negedge clk);
    play = 1'b0;
    shows = 0; cyc = 0;
    while (shows < 2 && cyc < 500) begin
      if (start_timer && led != 4'd0) shows++;
      if (shows < 2) begin @(negedge clk); cyc++; end
    end
    check("reach_show_step1", shows, 2);
    #2 reset = 1'b1;
    #1;
    check("abort_led", 32'(led), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_start_timer", 32'(start_timer), 0);
    @(negedge clk);
    reset = 1'b0;
    shows = 0;
    for (int c = 0; c < 30; c++) begin
      if (play_done || led != 4'd0 || busy) shows++;
      @(negedge clk);
    end
    check("abort_quiet", shows, 0);
    for (int i = 0; i < STEPS; i++) ref_mem[i] = 2'd0;
    verify_mem("abort_mem");

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/simon_pattern_player.md
SIMON_PATTERN_PLAYER -- requirements
Module: simon_pattern_player

Interface
REQ-001 Parameter STEPS_MAX, default 16, meaning pattern memory depth and maximum playable steps; the step-count, index and level widths below assume the default.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 new_game  input  1  single-cycle pulse requesting generation of a fresh pattern from seed.
REQ-005 seed  input  16  LFSR seed, sampled on accepted new_game.
REQ-006 play  input  1  single-cycle pulse requesting playback.
REQ-007 level  input  4  steps to play minus one, sampled on accepted play.
REQ-008 timer_done  input  1  from one-shot timer; high while its counter is zero.
REQ-009 start_timer  output  1  registered single-cycle pulse that (re)loads the timer.
REQ-010 led  output  4  registered one-hot colour display; 4'b0000 means dark.
REQ-011 busy  output  1  high while generating or playing.
REQ-012 play_done  output  1  registered single-cycle pulse at end of playback.
REQ-013 rd_idx  input  4  read index for the downstream input checker.
REQ-014 rd_color  output  2  combinational read of pattern memory at rd_idx.

Function
REQ-015 States SHALL be IDLE, GEN, SHOW, GAP, DONE; each timed state has an arm sub-phase.
REQ-016 In IDLE, new_game SHALL load lfsr with seed (16'hACE1 if seed==0), clear gen_idx, go to GEN.
REQ-017 In GEN, each cycle SHALL write lfsr[1:0] to mem[gen_idx], advance lfsr, increment gen_idx; after writing index 15, go to IDLE (exactly 16 GEN cycles).
REQ-018 LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, shifting left with feedback into bit 0.
REQ-019 In IDLE without new_game, play SHALL latch last=level, clear step, go to SHOW.
REQ-020 new_game and play together in IDLE: new_game wins, play dropped.
REQ-021 play or new_game while busy SHALL be ignored.
REQ-022 On SHOW entry: led=1<<mem[step] and start_timer=1 for the first cycle only.
REQ-023 Timed states SHALL ignore timer_done in the start_timer cycle and the cycle after (arm), and leave on the first later cycle with timer_done=1.
REQ-024 Leaving SHOW SHALL set led=0 and enter GAP, which pulses start_timer once under REQ-023 rules.
REQ-025 Leaving GAP: step==last -> DONE; else step+1 and SHOW.
REQ-026 DONE SHALL last one cycle with play_done=1, busy=0, then IDLE.
REQ-027 busy SHALL be high in GEN, SHOW, GAP; low in IDLE and DONE.
REQ-028 led SHALL be nonzero only in SHOW; start_timer never high for two consecutive cycles.
REQ-029 level=15 SHALL play all 16 steps; step SHALL never wrap.
REQ-030 Color c SHALL map to led bit c (0 red, 1 green, 2 blue, 3 yellow).

Reset
REQ-031 Reset SHALL force IDLE, led=0, start_timer=0, busy=0, play_done=0, step=0, gen_idx=0, lfsr=16'hACE1, all mem entries=0.
REQ-032 Reset mid-GEN or mid-playback SHALL abort immediately; no play_done.

Configuration
REQ-033 Macro PLAYER_GAP_EN: defined -> GAP state per REQ-024/025; undefined -> GAP removed, leaving SHOW applies REQ-025 directly (next SHOW in following cycle with fresh start_timer) and led goes 0 only on DONE entry.

Verification (timer stub: timer_done falls the cycle after start_timer, rises 4 cycles later)
REQ-034 reset, new_game seed=0 -> busy 16 cycles; mem equals LFSR sequence from 16'hACE1; rd_color matches reference model for rd_idx 0..15.
REQ-035 After gen, play level=2 (PLAYER_GAP_EN) -> three led pulses matching mem[0..2], each separated by dark gap; 6 start_timer pulses; one play_done; busy low.
REQ-036 play during playback and new_game during GEN -> no effect on led sequence or memory.
REQ-037 new_game and play same cycle in IDLE -> GEN only; no led activity, no play_done.
REQ-038 reset asserted mid-SHOW step 1 -> led=0, busy=0 immediately; no play_done; all mem reads 0.
REQ-039 Build without PLAYER_GAP_EN, play level=15 -> 16 back-to-back led steps, 16 start_timer pulses, one play_done.
